data_memory_block: RTL and testbench

//  Block-granular main data memory that sits directly below the data-cache controller in the

---
 rtl/data_memory_block_if.sv | 23 ++
 rtl/data_memory_block.sv | 104 ++++++++++
 tb/tb_data_memory_block.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_block_if.sv
// Request/response bundle between the data-cache controller (master) and the
// block-granular main memory (slave).
interface data_memory_block_if #(
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 28
);
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/data_memory_block.sv
// Main data memory below the data cache: busywait handshake with a fixed access
// latency, block-wide storage and wrap-around counters of completed reads/writes.
module data_memory_block #(
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 28,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic                clock,
  input  logic                reset,
  data_memory_block_if.slave  bus,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               op_wr_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic [31:0]        rd_cnt_q;
  logic [31:0]        wr_cnt_q;
  logic [BLOCK_W-1:0] mem_q [DEPTH];

  logic req_s;
  logic complete_s;

  assign req_s      = bus.mem_read | bus.mem_write;
  assign complete_s = (state_q == BUSY) && (cnt_q == CNT_ONE);

  // Busywait rises in the acceptance cycle itself and is forced low while reset is held.
  assign bus.mem_busywait = reset & ((state_q == BUSY) | ((state_q == IDLE) & req_s));
  assign bus.mem_readdata = rdata_q;
  assign read_count       = rd_cnt_q;
  assign write_count      = wr_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            idx_q   <= bus.mem_address[IDX_W-1:0];
            wdata_q <= bus.mem_writedata;
            op_wr_q <= bus.mem_write;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (op_wr_q) begin
              wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
              rdata_q  <= mem_q[idx_q];
              rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            state_q <= DONE;
          end else begin
            state_q <= BUSY;
          end
        end
        // One guaranteed non-busy cycle so the requester can drop its request.
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage has no reset; an access aborted by reset never reaches BUSY completion.
  always_ff @(posedge clock) begin
    if (complete_s && op_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_block.sv
// Directed checks of the data memory handshake, aliasing, read/write priority,
// mid-access reset, back-to-back held requests and a LATENCY=1 build.
module tb_data_memory_block;

  logic        clk;
  logic        rst_n;
  logic [31:0] rc0, wc0, rc1, wc1;
  int          vectors;
  int          miscompares;

  data_memory_block_if #(.BLOCK_W(128), .ADDR_W(28)) b0 ();
  data_memory_block_if #(.BLOCK_W(128), .ADDR_W(28)) b1 ();

  data_memory_block #(.BLOCK_W(128), .ADDR_W(28), .DEPTH(256), .LATENCY(5)) u_dut5 (
    .clock(clk), .reset(rst_n), .bus(b0.slave), .read_count(rc0), .write_count(wc0)
  );

  data_memory_block #(.BLOCK_W(128), .ADDR_W(28), .DEPTH(256), .LATENCY(1)) u_dut1 (
    .clock(clk), .reset(rst_n), .bus(b1.slave), .read_count(rc1), .write_count(wc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] d);
    if (sel == 0) begin
      b0.mem_read = rd; b0.mem_write = wr; b0.mem_address = a; b0.mem_writedata = d;
    end else begin
      b1.mem_read = rd; b1.mem_write = wr; b1.mem_address = a; b1.mem_writedata = d;
    end
  endtask

  function automatic logic busy(input int sel);
    return (sel == 0) ? b0.mem_busywait : b1.mem_busywait;
  endfunction

  function automatic logic [127:0] rdata(input int sel);
    return (sel == 0) ? b0.mem_readdata : b1.mem_readdata;
  endfunction

  // One access: returns busywait high-cycle count and readdata seen in the DONE cycle.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [27:0] a, input logic [127:0] d,
                        output int run, output logic [127:0] rd_done);
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    #1;
    run = 0;
    while (busy(sel) === 1'b1 && run < 50) begin
      run++;
      @(negedge clk);
      #1;
    end
    rd_done = rdata(sel);
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  localparam logic [127:0] A1  = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] A2  = 128'h0A0A_1111_2222_3333_4444_5555_6666_0A0A;
  localparam logic [127:0] BB  = 128'hBBBB_0000_BBBB_0000_BBBB_0000_BBBB_0000;
  localparam logic [127:0] CC  = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [127:0] DD  = 128'hDDDD_0123_4567_89AB_CDEF_0000_1111_DDDD;
  localparam logic [127:0] F40 = 128'h4040_4040_4040_4040_4040_4040_4040_4040;
  localparam logic [127:0] F50 = 128'h5050_5050_5050_5050_5050_5050_5050_5050;
  localparam logic [127:0] F7  = 128'h7777_0000_7777_0000_7777_0000_7777_0001;

  initial begin
    int             run;
    int             low;
    logic [127:0]   rdd;
    logic [127:0]   exp5 [3];

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(0, 1'b1, 1'b0, 28'h0, 128'h0);
    drive(1, 1'b0, 1'b0, 28'h0, 128'h0);

    // Reset: busywait low even with a request held; outputs cleared.
    @(negedge clk); #1;
    chk("rst_busy",   {127'd0, b0.mem_busywait}, 128'd0);
    chk("rst_rdata",  b0.mem_readdata, 128'd0);
    chk("rst_rcount", {96'd0, rc0}, 128'd0);
    chk("rst_wcount", {96'd0, wc0}, 128'd0);
    drive(0, 1'b0, 1'b0, 28'h0, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: write then read 0x10
    access(0, 1'b0, 1'b1, 28'h10, A1, run, rdd);
    chk("t1_wr_busy", 128'(run), 128'd6);
    chk("t1_wr_wc",   {96'd0, wc0}, 128'd1);
    chk("t1_wr_hold", rdd, 128'd0);
    access(0, 1'b1, 1'b0, 28'h10, 128'h0, run, rdd);
    chk("t1_rd_busy", 128'(run), 128'd6);
    chk("t1_rd_data", rdd, A1);
    chk("t1_rc",      {96'd0, rc0}, 128'd1);
    chk("t1_wc",      {96'd0, wc0}, 128'd1);

    // 2: index aliasing (0x101 maps to 0x01)
    access(0, 1'b0, 1'b1, 28'h001, A2, run, rdd);
    access(0, 1'b1, 1'b0, 28'h101, 128'h0, run, rdd);
    chk("t2_alias", rdd, A2);
    chk("t2_rc",    {96'd0, rc0}, 128'd2);

    // 3: simultaneous read+write is a write
    access(0, 1'b1, 1'b1, 28'h20, BB, run, rdd);
    chk("t3_busy", 128'(run), 128'd6);
    chk("t3_rc",   {96'd0, rc0}, 128'd2);
    chk("t3_wc",   {96'd0, wc0}, 128'd3);
    chk("t3_hold", rdd, A2);
    access(0, 1'b1, 1'b0, 28'h20, 128'h0, run, rdd);
    chk("t3_rd", rdd, BB);

    // 4: reset at C3 of a write aborts it
    access(0, 1'b0, 1'b1, 28'h30, DD, run, rdd);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 28'h30, CC);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_busy_lo", {127'd0, b0.mem_busywait}, 128'd0);
    chk("t4_rc",      {96'd0, rc0}, 128'd0);
    chk("t4_wc",      {96'd0, wc0}, 128'd0);
    chk("t4_rdata",   b0.mem_readdata, 128'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 28'h30, CC);
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 28'h30, 128'h0, run, rdd);
    chk("t4_old", rdd, DD);
    chk("t4_rc1", {96'd0, rc0}, 128'd1);
    chk("t4_wc0", {96'd0, wc0}, 128'd0);

    // 5: request held across three reads, address changed mid-BUSY
    access(0, 1'b0, 1'b1, 28'h40, F40, run, rdd);
    access(0, 1'b0, 1'b1, 28'h50, F50, run, rdd);
    exp5[0] = F40;
    exp5[1] = F50;
    exp5[2] = F40;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 28'h40, 128'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      run = 0;
      while (b0.mem_busywait === 1'b1 && run < 50) begin
        run++;
        if (run == 3) b0.mem_address = (k == 0) ? 28'h50 : 28'h40;
        @(negedge clk);
        #1;
      end
      chk($sformatf("t5_busy%0d", k), 128'(run), 128'd6);
      chk($sformatf("t5_data%0d", k), b0.mem_readdata, exp5[k]);
      if (k < 2) begin
        low = 0;
        while (b0.mem_busywait === 1'b0 && low < 50) begin
          low++;
          @(negedge clk);
          #1;
        end
        chk($sformatf("t5_gap%0d", k), 128'(low), 128'd1);
      end else begin
        drive(0, 1'b0, 1'b0, 28'h40, 128'h0);
      end
    end
    chk("t5_rc", {96'd0, rc0}, 128'd4);
    chk("t5_wc", {96'd0, wc0}, 128'd2);

    // 6: LATENCY=1 build
    access(1, 1'b0, 1'b1, 28'h7, F7, run, rdd);
    chk("t6_wr_busy", 128'(run), 128'd2);
    access(1, 1'b1, 1'b0, 28'h7, 128'h0, run, rdd);
    chk("t6_rd_busy", 128'(run), 128'd2);
    chk("t6_rd_data", rdd, F7);
    chk("t6_rc",      {96'd0, rc1}, 128'd1);
    chk("t6_wc",      {96'd0, wc1}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
